cp0_exc_ctrl: RTL and testbench
===============================

Name: cp0_exc_ctrl

Overview:
- Coprocessor-0 exception/interrupt controller. Consumer end of the per-stage exception detection chain: it receives the exception flag and ExcCode collected by the M stage, plus the six hardware interrupt lines.
- Decides whether to take an exception or interrupt and records Cause, EPC and BD. Manages SR.EXL/IE/IM.
- Serves mfc0/mtc0 and eret. Drives IntReq to the pipeline flush/redirect logic. On IntReq the pipeline redirects PC to the handler at 0x0000_4180.

Parameters:
- PRID, 32'h1805_0001, constant value read from PRId (reg 15).
- HANDLER_PC, 32'h0000_4180, value driven on HandlerPC.

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- A  in  5  CP0 register number for mfc0 read and mtc0 write.
- DIn  in  32  mtc0 write data.
- WE  in  1  mtc0 write enable.
- PC_M  in  32  PC of the instruction in M.
- BD_M  in  1  instruction in M is in a branch delay slot.
- Exc_M  in  1  instruction in M carries an exception.
- ExcCode_M  in  5  code: Int=0, AdEL=4, AdES=5, RI=10, Ov=12.
- HWInt  in  6  hardware interrupt lines, level sensitive.
- EXLClr  in  1  eret in M; clears SR.EXL.
- IntReq  out  1  take exception/interrupt this cycle; flush F–M.
- EPC  out  32  current EPC register, the eret target.
- HandlerPC  out  32  constant HANDLER_PC.
- DOut  out  32  mfc0 read data.

Behaviour:
- Registers and layout:
  - SR(12): IM[15:10], EXL[1], IE[0]. All other bits read 0.
  - Cause(13): BD[31], IP[15:10], ExcCode[6:2]. All other bits read 0.
  - EPC(14): 32 bits.
  - PRId(15): PRID.
- Reset: SR=0, Cause=0, EPC=0. IntReq=0 while reset is high, regardless of other inputs.
- Combinational request:
  - IntPend = |(HWInt & SR.IM) & SR.IE & ~SR.EXL
  - ExcPend = Exc_M & ~SR.EXL
  - IntReq = (IntPend | ExcPend) & ~reset
  - Same-cycle response, zero latency.
- Cause.IP is updated from HWInt every cycle, including when EXL=1. It is the only Cause field updated outside exception entry.
- Exception entry, on the edge where IntReq=1:
  - SR.EXL<=1.
  - Cause.ExcCode<=0 if IntPend, else ExcCode_M. Interrupt has priority over a simultaneous synchronous exception.
  - Cause.BD<=BD_M.
  - EPC<=BD_M ? PC_M-4 : PC_M, full 32-bit wrap, low bits not masked.
  - IE and IM unchanged.
- Nesting: while EXL=1, Exc_M and HWInt never raise IntReq. Cause.ExcCode, Cause.BD and EPC hold.
- mtc0 (WE=1):
  - A=12 writes SR.IM, EXL, IE from DIn; other DIn bits are ignored.
  - A=14 writes EPC with full DIn.
  - A=13, 15 and all other addresses: write ignored.
  - Write is discarded if IntReq=1 the same cycle, because entry wins.
- eret (EXLClr=1): SR.EXL<=0 at the edge.
  - Same-cycle mtc0 to SR: EXLClr wins on EXL; IM and IE take DIn.
  - EXLClr with EXL=0: no effect.
- DOut (combinational, by A): 12→SR, 13→Cause, 14→EPC, 15→PRId, else 0. A read in the same cycle as a write returns the pre-edge value.
- Reset asserted mid-handler clears EXL and all register state at that edge.

Test Plan:
- Reset, then read A=12/13/14/15 → 0, 0, 0, 32'h1805_0001. IntReq=0 with Exc_M=1 held during reset.
- Exc_M=1, ExcCode_M=12, PC_M=32'h0000_3010, BD_M=0 → IntReq=1 the same cycle. Next cycle EPC=32'h3010, Cause[6:2]=12, BD=0, SR.EXL=1. A second Exc_M the following cycle gives IntReq=0.
- Exception in a delay slot: BD_M=1, PC_M=32'h0000_3024, ExcCode_M=10 → EPC=32'h3020, Cause[31]=1, Cause[6:2]=10.
- mtc0 SR=32'h0000_0401 (IM[10]=1, IE=1), then HWInt=6'b000001 → IntReq=1, Cause.ExcCode=0. Repeat with HWInt[0]=1, Exc_M=1, ExcCode_M=4 in the same cycle → ExcCode=0 (interrupt wins).
- With EXL=1: EXLClr=1 together with mtc0 SR=32'h0000_0403 → next cycle SR=32'h0000_0401 (EXL cleared), and a pending enabled HWInt raises IntReq.
- mtc0 A=14 DIn=32'h0000_3abc in the same cycle as Exc_M=1 (EXL=0) → EPC=PC_M, not 32'h3abc. mtc0 A=13 → Cause unchanged.

Source files
------------

// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: CP0 exception/interrupt controller with SR, Cause, EPC and PRId
module cp0_exc_ctrl #(
    parameter logic [31:0] PRID       = 32'h1805_0001,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic [31:0] PC_M,
    input  logic        BD_M,
    input  logic        Exc_M,
    input  logic [4:0]  ExcCode_M,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        IntReq,
    output logic [31:0] EPC,
    output logic [31:0] HandlerPC,
    output logic [31:0] DOut
);
    logic [5:0]  im, ip;
    logic        exl, ie, bd;
    logic [4:0]  exc_code;
    logic [31:0] epc, sr, cause;
    logic        int_pend, exc_pend;

    assign int_pend  = |(HWInt & im) & ie & ~exl;
    assign exc_pend  = Exc_M & ~exl;
    assign IntReq    = (int_pend | exc_pend) & ~reset;
    assign EPC       = epc;
    assign HandlerPC = HANDLER_PC;
    assign sr        = {16'b0, im, 8'b0, exl, ie};
    assign cause     = {bd, 15'b0, ip, 3'b0, exc_code, 2'b0};

    always_comb
        DOut = A == 5'd12 ? sr :
               A == 5'd13 ? cause :
               A == 5'd14 ? epc :
               A == 5'd15 ? PRID : 32'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            im       <= '0;
            ip       <= '0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            exc_code <= '0;
            epc      <= '0;
        end else begin
            ip <= HWInt;
            if (IntReq) begin
                exl      <= 1'b1;
                exc_code <= int_pend ? 5'd0 : ExcCode_M;
                bd       <= BD_M;
                epc      <= BD_M ? PC_M - 32'd4 : PC_M;
            end else begin
                if (WE && A == 5'd12) begin
                    im  <= DIn[15:10];
                    ie  <= DIn[0];
                    exl <= DIn[1] & ~EXLClr;
                end else if (EXLClr)
                    exl <= 1'b0;
                if (WE && A == 5'd14)
                    epc <= DIn;
            end
        end
    end
endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb_cp0_exc_ctrl: directed and randomized checks of cp0_exc_ctrl against a word-level model
module tb_cp0_exc_ctrl;
    localparam logic [31:0] PRID = 32'h1805_0001;
    localparam logic [31:0] HPC  = 32'h0000_4180;

    logic        clk = 1'b0, reset = 1'b1;
    logic [4:0]  A = '0, ExcCode_M = '0;
    logic [31:0] DIn = '0, PC_M = '0;
    logic        WE = 1'b0, BD_M = 1'b0, Exc_M = 1'b0, EXLClr = 1'b0;
    logic [5:0]  HWInt = '0;
    logic        IntReq;
    logic [31:0] EPC, HandlerPC, DOut;
    int total = 0, bad = 0;
    logic [31:0] m_sr = '0, m_cause = '0, m_epc = '0;

    always #10 clk = ~clk;

    cp0_exc_ctrl dut (
        .clk(clk), .reset(reset), .A(A), .DIn(DIn), .WE(WE), .PC_M(PC_M), .BD_M(BD_M),
        .Exc_M(Exc_M), .ExcCode_M(ExcCode_M), .HWInt(HWInt), .EXLClr(EXLClr),
        .IntReq(IntReq), .EPC(EPC), .HandlerPC(HandlerPC), .DOut(DOut)
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    function automatic logic m_int();
        return ((HWInt & m_sr[15:10]) != 0) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic m_req();
        return !reset && (m_int() || (Exc_M && !m_sr[1]));
    endfunction

    function automatic logic [31:0] m_rd();
        case (A)
            5'd12: return m_sr;
            5'd13: return m_cause;
            5'd14: return m_epc;
            5'd15: return PRID;
            default: return 32'b0;
        endcase
    endfunction

    task automatic cyc();
        logic r, ip;
        #1;
        chk("IntReq", {31'b0, IntReq}, {31'b0, m_req()});
        chk("DOut", DOut, m_rd());
        chk("EPC", EPC, m_epc);
        chk("HandlerPC", HandlerPC, HPC);
        r  = m_req();
        ip = m_int();
        @(posedge clk);
        if (reset) begin
            m_sr = '0; m_cause = '0; m_epc = '0;
        end else begin
            m_cause[15:10] = HWInt;
            if (r) begin
                m_sr[1]       = 1'b1;
                m_cause[6:2]  = ip ? 5'd0 : ExcCode_M;
                m_cause[31]   = BD_M;
                m_epc         = BD_M ? PC_M - 32'd4 : PC_M;
            end else begin
                if (WE && A == 12) m_sr = DIn & 32'h0000_FC03;
                if (EXLClr) m_sr[1] = 1'b0;
                if (WE && A == 14) m_epc = DIn;
            end
        end
        @(negedge clk);
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string n);
        A = a;
        #1 chk(n, DOut, exp);
    endtask

    task automatic eret();
        Exc_M = 0; WE = 0; HWInt = 0; EXLClr = 1;
        cyc();
        EXLClr = 0;
    endtask

    initial begin
        Exc_M = 1; ExcCode_M = 12;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 chk("reset_intreq", {31'b0, IntReq}, 32'd0);
        cyc();
        cyc();
        reset = 0; Exc_M = 0;
        rd(12, 32'h0, "rst_sr");
        rd(13, 32'h0, "rst_cause");
        rd(14, 32'h0, "rst_epc");
        rd(15, PRID, "prid");

        Exc_M = 1; ExcCode_M = 12; PC_M = 32'h0000_3010; BD_M = 0;
        #1 chk("exc_req", {31'b0, IntReq}, 32'd1);
        cyc();
        Exc_M = 0;
        rd(14, 32'h0000_3010, "exc_epc");
        rd(13, 32'h0000_0030, "exc_cause");
        rd(12, 32'h0000_0002, "exc_sr");
        Exc_M = 1;
        #1 chk("nested_req", {31'b0, IntReq}, 32'd0);
        cyc();
        eret();

        Exc_M = 1; BD_M = 1; PC_M = 32'h0000_3024; ExcCode_M = 10;
        cyc();
        Exc_M = 0; BD_M = 0;
        rd(14, 32'h0000_3020, "bd_epc");
        rd(13, 32'h8000_0028, "bd_cause");
        eret();

        WE = 1; A = 12; DIn = 32'h0000_0401;
        cyc();
        WE = 0; HWInt = 6'b000001;
        #1 chk("int_req", {31'b0, IntReq}, 32'd1);
        cyc();
        HWInt = 0;
        rd(13, 32'h0000_0400, "int_cause");
        eret();
        HWInt = 6'b000001; Exc_M = 1; ExcCode_M = 4;
        cyc();
        Exc_M = 0;
        rd(13, 32'h0000_0400, "int_prio_cause");

        EXLClr = 1; WE = 1; A = 12; DIn = 32'h0000_0403;
        cyc();
        EXLClr = 0; WE = 0;
        rd(12, 32'h0000_0401, "eret_mtc0_sr");
        chk("eret_int_req", {31'b0, IntReq}, 32'd1);
        cyc();
        eret();

        Exc_M = 1; ExcCode_M = 12; WE = 1; A = 14; DIn = 32'h0000_3abc; PC_M = 32'h0000_5000;
        cyc();
        Exc_M = 0; A = 13; DIn = 32'hffff_ffff;
        cyc();
        WE = 0;
        rd(14, 32'h0000_5000, "entry_beats_mtc0");
        rd(13, 32'h0000_0030, "cause_ro");
        eret();

        for (int i = 0; i < 3000; i++) begin
            logic [4:0] codes [5] = '{5'd0, 5'd4, 5'd5, 5'd10, 5'd12};
            reset     = ($urandom % 64) == 0;
            Exc_M     = ($urandom % 4) == 0;
            ExcCode_M = codes[$urandom % 5];
            PC_M      = $urandom;
            BD_M      = $urandom % 2;
            HWInt     = ($urandom % 3) == 0 ? 6'($urandom) : 6'd0;
            EXLClr    = ($urandom % 4) == 0;
            WE        = ($urandom % 3) == 0;
            A         = ($urandom % 2) ? 5'(12 + $urandom % 4) : 5'($urandom);
            DIn       = $urandom;
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
